// File: rtl/led_mode_ctrl_pkg.sv
// Shared encodings for the LED mode sequencer and the pattern generators it drives.
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ModeFlash  = 2'b00,
    ModeShift  = 2'b01,
    ModeShift2 = 2'b10
  } mode_e;

  // One-hot {b,g,r} colour selects
  localparam logic [2:0] ColorRed   = 3'b001;
  localparam logic [2:0] ColorGreen = 3'b010;
  localparam logic [2:0] ColorBlue  = 3'b100;

  // Switch bit map
  localparam int unsigned SwRun    = 0;
  localparam int unsigned SwRateLo = 1;
  localparam int unsigned SwRateHi = 2;
  localparam int unsigned SwDir    = 3;

  // Button bit map
  localparam int unsigned BtnMode  = 0;
  localparam int unsigned BtnRed   = 1;
  localparam int unsigned BtnGreen = 2;
  localparam int unsigned BtnBlue  = 3;

  // FLASH -> SHIFT -> SHIFT2 -> FLASH; anything else recovers to FLASH
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      ModeFlash: return ModeShift;
      ModeShift: return ModeShift2;
      default:   return ModeFlash;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Single-bit button conditioner: 2-flop synchroniser, persistence debounce and a
// registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          rise_q;

  // Synchronise, count persistence of a differing level, flip stable and pulse on rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // Pulse is registered alongside the stable flip to keep total latency at DEB+3
        stable_q <= sync2_q;
        cnt_q    <= '0;
        rise_q   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern sequencer: debounced mode/colour buttons, switch-selected step prescaler,
// and registered direction/colour/mode outputs for the pattern datapath.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int unsigned NB_SW      = 4,
  parameter int unsigned NB_BTN     = 4,
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned LIM_0      = 2**20,
  parameter int unsigned LIM_1      = 2**22,
  parameter int unsigned LIM_2      = 2**24,
  parameter int unsigned LIM_3      = 2**26
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [1:0]        o_mode,
  output logic              o_mode_load,
  output logic              o_tick,
  output logic              o_dir,
  output logic [2:0]        o_color
);

  logic [NB_SW-1:0]      sw_meta_q;
  logic [NB_SW-1:0]      sw_sync_q;
  logic [NB_BTN-1:0]     btn_rise;
  logic [NB_COUNTER-1:0] lim_sel;
  logic [NB_COUNTER-1:0] presc_cnt_q;
  logic                  tick_q;
  mode_e                 mode_q;
  logic                  mode_load_q;
  logic [2:0]            color_q;
  logic                  dir_q;
  logic                  mode_step;

  // Switch synchroniser
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  for (genvar i = 0; i < NB_BTN; i++) begin : gen_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset_n(i_reset),
      .btn_raw(i_btn[i]),
      .rise   (btn_rise[i])
    );
  end

  assign mode_step = btn_rise[BtnMode];

  // Terminal count for the currently selected rate
  always_comb begin
    lim_sel = NB_COUNTER'(LIM_0);
    unique case (sw_sync_q[SwRateHi:SwRateLo])
      2'd0: lim_sel = NB_COUNTER'(LIM_0);
      2'd1: lim_sel = NB_COUNTER'(LIM_1);
      2'd2: lim_sel = NB_COUNTER'(LIM_2);
      2'd3: lim_sel = NB_COUNTER'(LIM_3);
      default: lim_sel = NB_COUNTER'(LIM_0);
    endcase
  end

  // Prescaler: a mode step restarts the period and wins over a coincident tick
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      presc_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else if (mode_step || !sw_sync_q[SwRun]) begin
      presc_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else if (presc_cnt_q == lim_sel) begin
      presc_cnt_q <= '0;
      tick_q      <= 1'b1;
    end else begin
      // Above a freshly lowered limit this just wraps through zero with no tick
      presc_cnt_q <= presc_cnt_q + NB_COUNTER'(1);
      tick_q      <= 1'b0;
    end
  end

  // Mode FSM with a load pulse coincident with every new mode value
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      mode_q      <= ModeFlash;
      mode_load_q <= 1'b0;
    end else begin
      mode_load_q <= 1'b0;
      case (mode_q)
        ModeFlash, ModeShift, ModeShift2: begin
          if (mode_step) begin
            mode_q      <= next_mode(mode_q);
            mode_load_q <= 1'b1;
          end
        end
        default: begin
          mode_q      <= ModeFlash;
          mode_load_q <= 1'b1;
        end
      endcase
    end
  end

  // Colour select (red > green > blue on simultaneous presses) and direction copy
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      color_q <= ColorRed;
      dir_q   <= 1'b0;
    end else begin
      dir_q <= sw_sync_q[SwDir];
      if (btn_rise[BtnRed]) begin
        color_q <= ColorRed;
      end else if (btn_rise[BtnGreen]) begin
        color_q <= ColorGreen;
      end else if (btn_rise[BtnBlue]) begin
        color_q <= ColorBlue;
      end
    end
  end

  assign o_mode      = mode_q;
  assign o_mode_load = mode_load_q;
  assign o_tick      = tick_q;
  assign o_dir       = dir_q;
  assign o_color     = color_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with a short debounce and 8-bit prescaler.
module tb_led_mode_ctrl;

  logic       clock = 1'b0;
  logic       i_reset;
  logic [3:0] i_sw;
  logic [3:0] i_btn;
  logic [1:0] o_mode;
  logic       o_mode_load;
  logic       o_tick;
  logic       o_dir;
  logic [2:0] o_color;

  int errors = 0;
  int checks = 0;
  int load_seen = 0;

  always #5 clock = ~clock;

  led_mode_ctrl #(
    .NB_SW     (4),
    .NB_BTN    (4),
    .NB_COUNTER(8),
    .DEB_CYCLES(4),
    .LIM_0     (3),
    .LIM_1     (7),
    .LIM_2     (15),
    .LIM_3     (31)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_sw       (i_sw),
    .i_btn      (i_btn),
    .o_mode     (o_mode),
    .o_mode_load(o_mode_load),
    .o_tick     (o_tick),
    .o_dir      (o_dir),
    .o_color    (o_color)
  );

  always @(posedge clock) begin
    if (o_mode_load === 1'b1) load_seen++;
  end

  typedef struct {
    logic [3:0] btn;
    logic [1:0] mode;
    logic [2:0] color;
    logic       load;
  } vec_t;

  vec_t       vecs[8];
  vec_t       sbq[$];
  logic [1:0] cur_mode;
  logic [2:0] cur_color;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Hold a button pattern 10 cycles; outputs must change exactly at the 7th edge
  task automatic press(input vec_t v);
    vec_t e;
    i_btn = v.btn;
    sbq.push_back(v);
    cyc(6);
    chk("pre_mode", 32'(o_mode), 32'(cur_mode));
    chk("pre_color", 32'(o_color), 32'(cur_color));
    chk("pre_load", 32'(o_mode_load), 32'd0);
    cyc(1);
    e = sbq.pop_front();
    chk("mode", 32'(o_mode), 32'(e.mode));
    chk("color", 32'(o_color), 32'(e.color));
    chk("load", 32'(o_mode_load), 32'(e.load));
    cyc(1);
    chk("load_off", 32'(o_mode_load), 32'd0);
    cyc(2);
    i_btn = 4'b0000;
    cyc(10);
    cur_mode  = e.mode;
    cur_color = e.color;
  endtask

  // Advance until o_tick is seen or the budget runs out; n = cycles advanced
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (o_tick !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("tick_found", 32'(o_tick), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    int   ticks;
    int   ls;
    vec_t v;

    vecs[0] = '{btn: 4'b0001, mode: 2'b01, color: 3'b001, load: 1'b1};
    vecs[1] = '{btn: 4'b0001, mode: 2'b10, color: 3'b001, load: 1'b1};
    vecs[2] = '{btn: 4'b0001, mode: 2'b00, color: 3'b001, load: 1'b1};
    vecs[3] = '{btn: 4'b0001, mode: 2'b01, color: 3'b001, load: 1'b1};
    vecs[4] = '{btn: 4'b1100, mode: 2'b01, color: 3'b010, load: 1'b0};
    vecs[5] = '{btn: 4'b1000, mode: 2'b01, color: 3'b100, load: 1'b0};
    vecs[6] = '{btn: 4'b0010, mode: 2'b01, color: 3'b001, load: 1'b0};
    vecs[7] = '{btn: 4'b0101, mode: 2'b10, color: 3'b010, load: 1'b1};

    // Reset
    i_reset = 1'b0;
    i_sw    = 4'b0000;
    i_btn   = 4'b0000;
    #40;
    i_reset = 1'b1;
    cyc(1);
    chk("rst_mode", 32'(o_mode), 32'd0);
    chk("rst_color", 32'(o_color), 32'b001);
    chk("rst_tick", 32'(o_tick), 32'd0);
    chk("rst_load", 32'(o_mode_load), 32'd0);
    chk("rst_dir", 32'(o_dir), 32'd0);
    cur_mode  = 2'b00;
    cur_color = 3'b001;

    // Glitch shorter than the debounce window
    ls    = load_seen;
    i_btn = 4'b0001;
    cyc(3);
    i_btn = 4'b0000;
    cyc(12);
    chk("glitch_mode", 32'(o_mode), 32'd0);
    chk("glitch_load", 32'(load_seen), 32'(ls));

    // Table of presses: mode sequence and colour priority
    for (int i = 0; i < 8; i++) press(vecs[i]);

    // Prescaler rates
    i_sw = 4'b0001;
    cyc(4);
    wait_tick(20, n);
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      wait_tick(40, n);
      chk("period_lim3", 32'(n + 1), 32'd4);
    end
    i_sw = 4'b0111;
    cyc(4);
    wait_tick(300, n);
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      wait_tick(100, n);
      chk("period_lim31", 32'(n + 1), 32'd32);
    end
    i_sw = 4'b0000;
    cyc(4);
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_tick === 1'b1) ticks++;
      cyc(1);
    end
    chk("stopped_ticks", 32'(ticks), 32'd0);
    chk("stopped_cnt", 32'(dut.presc_cnt_q), 32'd0);

    // Mode step coincident with the terminal count
    i_sw = 4'b1001;
    cyc(4);
    chk("dir", 32'(o_dir), 32'd1);
    wait_tick(20, n);          // edge T
    cyc(1);                    // edge T+1
    i_btn = 4'b0001;
    cyc(3);                    // edge T+4
    chk("align_tick_T4", 32'(o_tick), 32'd1);
    cyc(4);                    // edge T+8
    chk("align_tick_off", 32'(o_tick), 32'd0);
    chk("align_load", 32'(o_mode_load), 32'd1);
    chk("align_mode", 32'(o_mode), 32'd0);
    chk("align_cnt", 32'(dut.presc_cnt_q), 32'd0);
    ticks = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (o_tick === 1'b1) ticks++;
    end
    chk("align_gap", 32'(ticks), 32'd0);
    cyc(1);                    // edge T+12
    chk("align_next_tick", 32'(o_tick), 32'd1);
    i_btn = 4'b0000;
    cyc(10);
    cur_mode = 2'b00;
    i_sw     = 4'b0000;
    cyc(4);

    // Move to a non-FLASH mode, then reset in the middle of a debounce
    v = '{btn: 4'b0001, mode: 2'b01, color: 3'b010, load: 1'b1};
    press(v);
    ls    = load_seen;
    i_btn = 4'b0001;
    cyc(4);
    i_reset = 1'b0;
    i_btn   = 4'b0000;
    #1;
    chk("midrst_mode", 32'(o_mode), 32'd0);
    chk("midrst_color", 32'(o_color), 32'b001);
    #20;
    i_reset = 1'b1;
    cyc(20);
    chk("postrst_mode", 32'(o_mode), 32'd0);
    chk("postrst_load", 32'(load_seen), 32'(ls));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
